core_ctrl: RTL and testbench

CORE_CTRL -- requirements
Module: core_ctrl

---
 rtl/core_ctrl_pkg.sv | 24 ++
 rtl/core_ctrl_if.sv | 37 +++
 rtl/core_ctrl.sv | 93 +++++++++
 tb/tb_core_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared types and constants for the core controller.
//   state_t      - controller FSM state encoding (also exported on state_o)
//   RESET_PC_DEF - default reset program counter
//   ALIGN_MASK   - low PC bits that must be zero for a legal instruction address
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] ALIGN_MASK   = 32'h0000_0003;

  function automatic logic pc_aligned(input logic [31:0] a);
    return (a & ALIGN_MASK) == 32'h0;
  endfunction

endpackage

// File: rtl/core_ctrl_if.sv
// core_ctrl_if: bundles the controller's fetch, decode, datapath, memory and
// status signals.
//   master - the controller (drives requests, inst, pc, status)
//   slave  - the surrounding core (IFU, decoder, datapath, LSU)
interface core_ctrl_if;
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        ifu_valid;
  logic [31:0] ifu_rdata;
  logic [31:0] inst;
  logic        dec_illegal;
  logic        dec_ebreak;
  logic        dec_load;
  logic        dec_store;
  logic        dec_wen;
  logic [31:0] next_pc;
  logic        lsu_req;
  logic        lsu_done;
  logic        rf_wen;
  logic [31:0] pc;
  logic [31:0] instret;
  logic        halted;
  logic        error;
  logic [2:0]  state_o;

  modport master (
    output ifu_req, ifu_addr, inst, lsu_req, rf_wen, pc, instret, halted, error, state_o,
    input  ifu_valid, ifu_rdata, dec_illegal, dec_ebreak, dec_load, dec_store, dec_wen,
           next_pc, lsu_done
  );

  modport slave (
    input  ifu_req, ifu_addr, inst, lsu_req, rf_wen, pc, instret, halted, error, state_o,
    output ifu_valid, ifu_rdata, dec_illegal, dec_ebreak, dec_load, dec_store, dec_wen,
           next_pc, lsu_done
  );
endinterface

// File: rtl/core_ctrl.sv
// core_ctrl: multi-cycle instruction sequencer
// FETCH -> DECODE -> EXEC|MEM -> WB, with absorbing HALT and ERROR states.
//   clk, rst - clock; synchronous active-high reset
//   bus      - core_ctrl_if.master: IFU request/response, decoder flags,
//              next_pc, LSU handshake, rf_wen, pc, instret, halted,
//              error, state_o
// FETCH waits at most FETCH_TIMEOUT cycles for ifu_valid. A WB whose
// next_pc is misaligned retires nothing and traps to ERROR.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = RESET_PC_DEF,
  parameter int          FETCH_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  core_ctrl_if.master  bus
);

  localparam int             WCW       = $clog2(FETCH_TIMEOUT + 1);
  // Last FETCH cycle index: valid here still wins, otherwise we trap.
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(FETCH_TIMEOUT - 1);

  state_t          state, state_nx;
  logic [WCW-1:0]  wait_cnt;
  logic [31:0]     pc_q, inst_q, instret_q;
  logic            wb_ok;

  assign wb_ok = pc_aligned(bus.next_pc);

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH: begin
        if (bus.ifu_valid)             state_nx = S_DECODE;
        else if (wait_cnt == WAIT_LAST) state_nx = S_ERROR;
      end
      S_DECODE: begin
        if (bus.dec_illegal)                   state_nx = S_ERROR;
        else if (bus.dec_ebreak)               state_nx = S_HALT;
        else if (bus.dec_load | bus.dec_store) state_nx = S_MEM;
        else                                   state_nx = S_EXEC;
      end
      S_EXEC:  state_nx = S_WB;
      S_MEM:   if (bus.lsu_done) state_nx = S_WB;
      S_WB:    state_nx = wb_ok ? S_FETCH : S_ERROR;
      S_HALT:  state_nx = S_HALT;
      S_ERROR: state_nx = S_ERROR;
      default: state_nx = S_ERROR;
    endcase
  end

  // Instruction capture, fetch wait counter and retirement.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      instret_q <= '0;
      wait_cnt  <= '0;
    end else begin
      if (state == S_FETCH) begin
        if (bus.ifu_valid) begin
          inst_q   <= bus.ifu_rdata;
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end
      if (state == S_WB && wb_ok) begin
        pc_q      <= bus.next_pc;
        instret_q <= instret_q + 32'd1; // wraps silently
      end
    end
  end

  assign bus.ifu_req  = (state == S_FETCH);
  assign bus.ifu_addr = pc_q;
  assign bus.lsu_req  = (state == S_MEM);
  // Only output that looks at inputs: the write is suppressed on a trapping WB.
  assign bus.rf_wen   = (state == S_WB) && wb_ok && bus.dec_wen;
  assign bus.halted   = (state == S_HALT);
  assign bus.error    = (state == S_ERROR);
  assign bus.state_o  = state;
  assign bus.inst     = inst_q;
  assign bus.pc       = pc_q;
  assign bus.instret  = instret_q;

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: builds a cycle timeline from instruction descriptors
// (fetch wait, kind, memory wait, next_pc), drives it into core_ctrl and
// checks every cycle against the timeline, plus hand-computed literal points.
module tb_core_ctrl;
  import core_ctrl_pkg::*;

  localparam int FT   = 255;
  localparam int MAXC = 2048;
  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_EBRK = 3, K_ILL = 4;
  localparam int L_WEN = 0, L_PC = 1, L_RET = 2, L_LREQ = 3, L_ERR = 4,
                 L_IREQ = 5, L_HALT = 6, L_ST = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  core_ctrl_if bus();

  core_ctrl #(.RESET_PC(32'h8000_0000), .FETCH_TIMEOUT(FT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stimulus timeline
  logic        s_rst  [MAXC];
  logic        s_val  [MAXC];
  logic        s_done [MAXC];
  logic [31:0] s_rdata[MAXC];
  logic [31:0] s_npc  [MAXC];
  logic [4:0]  s_fl   [MAXC]; // {illegal, ebreak, load, store, wen}
  // Expected timeline
  logic        e_chk  [MAXC];
  logic [2:0]  e_st   [MAXC];
  logic        e_wen  [MAXC];
  logic [31:0] e_pc   [MAXC];
  logic [31:0] e_ret  [MAXC];
  logic [31:0] e_inst [MAXC];

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       nm;
  } lit_t;
  lit_t lits[$];

  int n = 0;
  logic [31:0] mpc = 32'h8000_0000, mret = 0, minst = 0;
  int mterm = 0; // 0 running, 1 halted, 2 error

  int tests = 0, fails = 0;
  int cur = 0;
  bit running = 0;

  task automatic emit(input logic r, input logic v, input logic d,
                      input logic [31:0] rd, input logic [31:0] np,
                      input logic [4:0] fl, input logic chk,
                      input state_t st, input logic wen);
    s_rst[n] = r; s_val[n] = v; s_done[n] = d; s_rdata[n] = rd;
    s_npc[n] = np; s_fl[n] = fl;
    e_chk[n] = chk; e_st[n] = st; e_wen[n] = wen;
    e_pc[n] = mpc; e_ret[n] = mret; e_inst[n] = minst;
    n++;
  endtask

  task automatic lit(input int c, input int sig, input logic [31:0] val, input string nm);
    lit_t l;
    l.cyc = c; l.sig = sig; l.val = val; l.nm = nm;
    lits.push_back(l);
  endtask

  // Reset for k cycles with every other input asserted; the first reset
  // cycle still shows the pre-reset state, so it is not checked.
  task automatic do_reset(input int k);
    emit(1, 1, 1, 32'hFFFF_FFFF, 32'h1, 5'b11111, 0, S_FETCH, 0);
    mpc = 32'h8000_0000; mret = 0; minst = 0; mterm = 0;
    for (int j = 1; j < k; j++)
      emit(1, 1, 1, 32'hFFFF_FFFF, 32'h1, 5'b11111, 1, S_FETCH, 0);
  endtask

  // Terminal-state hold with fetch/memory noise that must be ignored.
  task automatic idle(input int k);
    for (int j = 0; j < k; j++)
      emit(0, 1, 1, 32'hDEAD_BEEF, 32'h0, 5'b00101, 1,
           (mterm == 1) ? S_HALT : S_ERROR, 0);
  endtask

  // One instruction: fw fetch wait cycles, mw MEM cycles (done on the last),
  // abort>0 stops after that many MEM cycles without done.
  task automatic run_insn(input int fw, input int kind, input int mw,
                          input logic wen, input logic [31:0] npc,
                          input logic [31:0] rd, input logic noise,
                          input int abort);
    logic [4:0] fl;
    bit aligned;
    fl = {kind == K_ILL, kind == K_EBRK, kind == K_LD, kind == K_ST, wen};
    if (fw >= FT) begin
      for (int j = 0; j < FT; j++) emit(0, 0, noise, rd, npc, fl, 1, S_FETCH, 0);
      mterm = 2;
      return;
    end
    for (int j = 0; j < fw; j++) emit(0, 0, noise, rd, npc, fl, 1, S_FETCH, 0);
    emit(0, 1, noise, rd, npc, fl, 1, S_FETCH, 0);
    minst = rd;
    emit(0, noise, noise, 32'hBAD0_BAD0, npc, fl, 1, S_DECODE, 0);
    if (kind == K_ILL)  begin mterm = 2; return; end
    if (kind == K_EBRK) begin mterm = 1; return; end
    if (kind == K_LD || kind == K_ST) begin
      if (abort > 0) begin
        for (int j = 0; j < abort; j++) emit(0, noise, 0, rd, npc, fl, 1, S_MEM, 0);
        return;
      end
      for (int j = 0; j < mw - 1; j++) emit(0, noise, 0, rd, npc, fl, 1, S_MEM, 0);
      emit(0, noise, 1, rd, npc, fl, 1, S_MEM, 0);
    end else begin
      emit(0, noise, noise, rd, npc, fl, 1, S_EXEC, 0);
    end
    aligned = (npc % 4) == 0;
    emit(0, noise, noise, rd, npc, fl, 1, S_WB, aligned && wen);
    if (aligned) begin mpc = npc; mret = mret + 1; end
    else mterm = 2;
  endtask

  task automatic build();
    int t;
    do_reset(2);
    // addi: rf_wen on the 4th cycle, then pc/instret advance
    t = n; run_insn(0, K_ALU, 0, 1, 32'h8000_0004, 32'h0010_0093, 0, 0);
    lit(t + 3, L_WEN, 1, "addi_rfwen_c4");
    lit(t + 3, L_PC, 32'h8000_0000, "addi_pc_before_wb");
    lit(t + 4, L_PC, 32'h8000_0004, "addi_pc");
    lit(t + 4, L_RET, 1, "addi_instret");
    // load, done on the 3rd MEM cycle
    t = n; run_insn(0, K_LD, 3, 1, 32'h8000_0008, 32'h0000_2103, 0, 0);
    lit(t + 2, L_LREQ, 1, "ld_lsureq_m1");
    lit(t + 4, L_LREQ, 1, "ld_lsureq_m3");
    lit(t + 5, L_LREQ, 0, "ld_lsureq_wb");
    lit(t + 5, L_WEN, 1, "ld_rfwen");
    lit(t + 6, L_PC, 32'h8000_0008, "ld_pc");
    // store with noise, then a non-writing ALU op with noise
    run_insn(1, K_ST, 1, 0, 32'h8000_0010, 32'h0011_2023, 1, 0);
    run_insn(3, K_ALU, 0, 0, 32'h8000_0014, 32'h0000_0013, 1, 0);
    // valid on the last allowed fetch cycle, twice (counter must clear)
    t = n; run_insn(FT - 1, K_ALU, 0, 1, 32'h8000_0018, 32'h0020_0113, 0, 0);
    lit(t + FT, L_ST, S_DECODE, "late_valid_decode");
    run_insn(FT - 1, K_ALU, 0, 1, 32'h8000_001C, 32'h0030_0193, 1, 0);
    // misaligned jump target traps from WB
    t = n; run_insn(0, K_ALU, 0, 1, 32'h8000_0102, 32'h1000_006F, 0, 0);
    lit(t + 3, L_WEN, 0, "jmp_no_rfwen");
    lit(t + 4, L_ERR, 1, "jmp_error");
    lit(t + 4, L_PC, 32'h8000_001C, "jmp_pc_hold");
    idle(3);
    do_reset(2);
    // ebreak halts after DECODE
    t = n; run_insn(0, K_EBRK, 0, 0, 32'h8000_0004, 32'h0010_0073, 1, 0);
    lit(t + 2, L_HALT, 1, "ebreak_halted");
    lit(t + 2, L_PC, 32'h8000_0000, "ebreak_pc");
    lit(t + 2, L_RET, 0, "ebreak_instret");
    idle(4);
    do_reset(2);
    lit(n, L_PC, 32'h8000_0000, "halt_reset_pc");
    // fetch timeout
    t = n; run_insn(FT, K_ALU, 0, 1, 32'h8000_0004, 32'h0, 0, 0);
    lit(t + FT - 1, L_IREQ, 1, "to_last_fetch");
    lit(t + FT, L_ERR, 1, "to_error");
    lit(t + FT, L_IREQ, 0, "to_ifureq_low");
    idle(3);
    do_reset(2);
    // illegal
    t = n; run_insn(0, K_ILL, 0, 1, 32'h8000_0004, 32'hFFFF_FFFF, 1, 0);
    lit(t + 2, L_ERR, 1, "illegal_error");
    idle(2);
    do_reset(2);
    // reset in the middle of a MEM wait
    run_insn(0, K_ALU, 0, 1, 32'h8000_0004, 32'h0010_0093, 0, 0);
    run_insn(0, K_LD, 0, 1, 32'h8000_0008, 32'h0000_2103, 0, 2);
    t = n; do_reset(2);
    lit(t, L_LREQ, 1, "mem_rst_cycle_lsureq");
    lit(t + 1, L_LREQ, 0, "mem_rst_lsureq_drop");
    lit(t + 1, L_ST, S_FETCH, "mem_rst_state");
    lit(t + 1, L_RET, 0, "mem_rst_instret");
    lit(t + 1, L_PC, 32'h8000_0000, "mem_rst_pc");
    run_insn(0, K_ALU, 0, 1, 32'h8000_0004, 32'h0010_0093, 0, 0);
  endtask

  task automatic apply(input int k);
    rst             = s_rst[k];
    bus.ifu_valid   = s_val[k];
    bus.lsu_done    = s_done[k];
    bus.ifu_rdata   = s_rdata[k];
    bus.next_pc     = s_npc[k];
    bus.dec_illegal = s_fl[k][4];
    bus.dec_ebreak  = s_fl[k][3];
    bus.dec_load    = s_fl[k][2];
    bus.dec_store   = s_fl[k][1];
    bus.dec_wen     = s_fl[k][0];
  endtask

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, k, act, exp);
    end
  endtask

  function automatic logic [31:0] sigval(input int sig);
    case (sig)
      L_WEN:  return {31'b0, bus.rf_wen};
      L_PC:   return bus.pc;
      L_RET:  return bus.instret;
      L_LREQ: return {31'b0, bus.lsu_req};
      L_ERR:  return {31'b0, bus.error};
      L_IREQ: return {31'b0, bus.ifu_req};
      L_HALT: return {31'b0, bus.halted};
      default: return {29'b0, bus.state_o};
    endcase
  endfunction

  // Single compare process: timeline expectations plus literal points.
  always @(negedge clk) begin
    int k;
    if (running) begin
      k = cur;
      if (e_chk[k]) begin
        chk("state",   k, {29'b0, bus.state_o}, {29'b0, e_st[k]});
        chk("ifu_req", k, {31'b0, bus.ifu_req}, {31'b0, e_st[k] == S_FETCH});
        chk("lsu_req", k, {31'b0, bus.lsu_req}, {31'b0, e_st[k] == S_MEM});
        chk("halted",  k, {31'b0, bus.halted},  {31'b0, e_st[k] == S_HALT});
        chk("error",   k, {31'b0, bus.error},   {31'b0, e_st[k] == S_ERROR});
        chk("rf_wen",  k, {31'b0, bus.rf_wen},  {31'b0, e_wen[k]});
        chk("pc",      k, bus.pc, e_pc[k]);
        chk("ifu_addr",k, bus.ifu_addr, e_pc[k]);
        chk("instret", k, bus.instret, e_ret[k]);
        chk("inst",    k, bus.inst, e_inst[k]);
      end
      foreach (lits[i])
        if (lits[i].cyc == k) chk(lits[i].nm, k, sigval(lits[i].sig), lits[i].val);
    end
  end

  initial begin
    build();
    apply(0);
    @(posedge clk); #1;
    running = 1;
    for (int k = 0; k < n; k++) begin
      cur = k;
      apply(k);
      @(posedge clk); #1;
    end
    running = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
